// File: rtl/mii_tx_framer.sv
// MII transmit framer: byte stream in, nibble-serial Ethernet frame out.
// Emits preamble, SFD, payload (low nibble first), zero pad up to MIN_BYTES,
// FCS from a nibble-wide reflected CRC-32, then the inter-frame gap.
// A missing byte at a ready slot truncates the frame and drains the source.
module mii_tx_framer #(
  parameter int MIN_BYTES   = 60,
  parameter int IFG_NIBBLES = 24,
  parameter int PRE_NIBBLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       busy,
  output logic       underrun
);

  localparam int BW   = $clog2(MIN_BYTES + 1);
  localparam int CMAX = (PRE_NIBBLES > IFG_NIBBLES) ? PRE_NIBBLES : IFG_NIBBLES;
  localparam int CW   = $clog2(CMAX + 8);

  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_NIBBLES - 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_NIBBLES - 2);
  localparam logic [CW-1:0] FCS_LAST = CW'(7);
  localparam logic [BW-1:0] MIN_B    = BW'(MIN_BYTES);
  localparam logic [BW-1:0] MIN_M1   = BW'(MIN_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, PRE, SFD, DLO, DHI, PAD, FCS, IFG, DROP
  } state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   byte_cnt;
  logic [7:0]      byte_q;
  logic            last_seen;
  logic [31:0]     crc;
  logic [3:0]      nxt_txd;
  logic            nxt_tx_en;
  logic            hs;

  // One reflected CRC-32 step over a nibble, LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c ^ {28'd0, d};
    for (int i = 0; i < 4; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Payload byte taken from the source (DROP acceptances are discarded).
  assign hs = s_valid && s_ready && (state == SFD || state == DHI);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt_state;
  end

  // Next-state logic.
  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE: if (s_valid) nxt_state = PRE;
      PRE:  if (cnt == PRE_LAST) nxt_state = SFD;
      SFD:  nxt_state = s_valid ? DLO : DROP;
      DLO:  nxt_state = DHI;
      DHI: begin
        if (s_ready)                nxt_state = s_valid ? DLO : DROP;
        else if (byte_cnt < MIN_B)  nxt_state = PAD;
        else                        nxt_state = FCS;
      end
      PAD:  if (cnt[0] && byte_cnt == MIN_M1) nxt_state = FCS;
      FCS:  if (cnt == FCS_LAST) nxt_state = IFG;
      IFG:  if (cnt == IFG_LAST) nxt_state = IDLE;
      DROP: if (s_valid && s_last) nxt_state = IFG;
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs: handshake/status from the current state, MII nibble for the next one.
  always_comb begin
    s_ready = 1'b0;
    unique case (state)
      SFD, DHI: s_ready = !last_seen;
      DROP:     s_ready = 1'b1;
      default:  s_ready = 1'b0;
    endcase
    busy     = (state != IDLE);
    underrun = (state == SFD || state == DHI) && s_ready && !s_valid;

    nxt_tx_en = 1'b0;
    nxt_txd   = 4'h0;
    unique case (nxt_state)
      PRE: begin nxt_tx_en = 1'b1; nxt_txd = 4'h5;         end
      SFD: begin nxt_tx_en = 1'b1; nxt_txd = 4'hD;         end
      DLO: begin nxt_tx_en = 1'b1; nxt_txd = s_data[3:0]; end
      DHI: begin nxt_tx_en = 1'b1; nxt_txd = byte_q[7:4]; end
      PAD: begin nxt_tx_en = 1'b1; nxt_txd = 4'h0;         end
      FCS: begin nxt_tx_en = 1'b1; nxt_txd = ~crc[3:0];    end
      default: begin nxt_tx_en = 1'b0; nxt_txd = 4'h0;     end
    endcase
  end

  // Registered MII pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      txd   <= 4'h0;
      tx_en <= 1'b0;
    end else begin
      txd   <= nxt_txd;
      tx_en <= nxt_tx_en;
    end
  end

  // Shared sequencing counter: restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst)                    cnt <= '0;
    else if (nxt_state != state) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  // Byte latch, saturating byte count and end-of-payload flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_q    <= 8'h00;
      byte_cnt  <= '0;
      last_seen <= 1'b0;
    end else begin
      if (hs) byte_q <= s_data;
      if (state == IDLE) begin
        byte_cnt  <= '0;
        last_seen <= 1'b0;
      end else begin
        if (hs && byte_cnt < MIN_B)  byte_cnt <= byte_cnt + 1'b1;
        else if (state == PAD && cnt[0]) byte_cnt <= byte_cnt + 1'b1;
        if (hs && s_last) last_seen <= 1'b1;
      end
    end
  end

  // CRC absorbs each data/pad nibble as it is scheduled; FCS shifts it out.
  always_ff @(posedge clk) begin
    if (!rst)                                            crc <= '1;
    else if (nxt_state == SFD)                           crc <= '1;
    else if (nxt_state == DLO || nxt_state == DHI ||
             nxt_state == PAD)                           crc <= crc_nib(crc, nxt_txd);
    else if (nxt_state == FCS)                           crc <= {4'h0, crc[31:4]};
  end

endmodule
